cordic: RTL and testbench
=========================

CORDIC -- requirements
Module: cordic

Interface
REQ-001 Parameter ITER, default 8, number of CORDIC micro-rotation pipeline stages (fixed 8 in this release).
REQ-002 Parameter IW, default 12, internal signed datapath width for x, y, z.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in  input  8  signed angle in radians, Q2.5 (LSB = 1/32 rad, range -4.0..+3.97).
REQ-006 sine  output  8  signed sin(in), Q1.6 (64 = 1.0).
REQ-007 cosine  output  8  signed cos(in), Q1.6 (64 = 1.0).

Function
REQ-008 Fully pipelined, rotation-mode CORDIC; accepts a new in every cycle, no handshake, results emerge in input order.
REQ-009 Latency exactly ITER+2 = 10 cycles: 1 input/pre-rotation register, ITER iteration stages, 1 output register.
REQ-010 Input stage: z0 = in sign-extended and left-shifted by 4 (Q2.9, 12 bits); x0 = 622 (1/K = 0.60725 in Q2.10); y0 = 0.
REQ-011 Stage i (0..7): d = sign(z) (z>=0 gives +1); x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan_i; shifts arithmetic.
REQ-012 atan table, Q2.9: 402, 237, 125, 64, 32, 16, 8, 4.
REQ-013 Output stage: cosine = x, sine = y, each rounded (add 8, arithmetic shift right 4) from Q2.10 to Q1.6 and saturated to [-128, 127].
REQ-014 Accuracy: each output within +/-2 LSB of round(64*trig(angle)) for angles inside the supported range.
REQ-015 Supported range without quadrant extension: |z0| <= 804 (pi/2); z0 beyond it is clamped to +/-804 at the input stage.
REQ-016 Arithmetic never wraps internally; IW=12 provides headroom for |x|,|y| <= 1.65 in Q2.10.

Reset
REQ-017 While rst=1, all pipeline registers and outputs sine, cosine are 0, asynchronously.
REQ-018 Reset mid-operation discards all in-flight samples; first valid result appears 10 rising edges after rst deasserts with stable in.
REQ-019 Between rst release and pipeline fill, outputs carry the reset-seeded datapath values (x0 of zero-filled stages), which are don't-care for checking.

Configuration
REQ-020 Macro CORDIC_QUAD_EXT_EN: when defined, z0 > 804 is replaced by z0 - 1608, z0 < -804 by z0 + 1608, a negate flag is piped alongside, and both outputs are negated (then saturated) at the output stage.
REQ-021 When CORDIC_QUAD_EXT_EN is undefined, REQ-015 clamping applies and no negate flag exists.

Structure
REQ-022 Package cordic_pkg holds ITER, IW, the atan table constants, the 1/K constant (622), and PI_HALF (804) / PI (1608) in Q2.9.
REQ-023 One sub-module cordic_stage (one micro-rotation plus registers, stage index as parameter) instantiated ITER times via generate.

Verification
REQ-024 in=47 (1.469 rad), hold 10 cycles -> sine 64 (+/-2), cosine 7 (+/-2).
REQ-025 in=0 -> sine 0 (+/-2), cosine 64 (+/-2), after exactly 10 cycles.
REQ-026 in=-25 (-0.781 rad) -> sine -45 (+/-2), cosine 45 (+/-2).
REQ-027 in=100 (3.125 rad) -> with CORDIC_QUAD_EXT_EN: sine 1 (+/-2), cosine -64 (+/-2); without: sine 64, cosine 0 (+/-2).
REQ-028 Back-to-back in = 0, 47, -25 on consecutive cycles -> results on consecutive cycles 10 later, same order.
REQ-029 Assert rst for 1 cycle mid-stream -> sine=cosine=0 immediately and asynchronously; correct results resume 10 cycles after release.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: pipeline depth, datapath width, atan table (Q2.9), gain seed (Q2.10), angle limits.
// Build macro CORDIC_QUAD_EXT_EN (see cordic.sv) does not change anything here.
package cordic_pkg;
  localparam int ITER    = 8;
  localparam int IW      = 12;
  localparam int INV_K   = 622;
  localparam int PI_HALF = 804;
  localparam int PI      = 1608;

  localparam int ATAN_0 = 402;
  localparam int ATAN_1 = 237;
  localparam int ATAN_2 = 125;
  localparam int ATAN_3 = 64;
  localparam int ATAN_4 = 32;
  localparam int ATAN_5 = 16;
  localparam int ATAN_6 = 8;
  localparam int ATAN_7 = 4;

  function automatic int atan_q9(input int idx);
    case (idx)
      0:       return ATAN_0;
      1:       return ATAN_1;
      2:       return ATAN_2;
      3:       return ATAN_3;
      4:       return ATAN_4;
      5:       return ATAN_5;
      6:       return ATAN_6;
      7:       return ATAN_7;
      default: return 0;
    endcase
  endfunction
endpackage

// File: rtl/cordic_stage.sv
// One registered rotation-mode micro-rotation; IDX selects shift amount and atan constant.
// Optional negate flag rides alongside when CORDIC_QUAD_EXT_EN is defined.
module cordic_stage #(
  parameter int IDX = 0,
  parameter int IW  = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] x,
  input  logic [IW-1:0] y,
  input  logic [IW-1:0] z,
`ifdef CORDIC_QUAD_EXT_EN
  input  logic          neg,
  output logic          neg_r,
`endif
  output logic [IW-1:0] x_r,
  output logic [IW-1:0] y_r,
  output logic [IW-1:0] z_r
);
  import cordic_pkg::*;

  localparam logic signed [IW-1:0] ATAN = IW'(atan_q9(IDX));

  logic signed [IW-1:0] xs, ys, zs, x_sh, y_sh;

  assign xs   = signed'(x);
  assign ys   = signed'(y);
  assign zs   = signed'(z);
  assign x_sh = xs >>> IDX;
  assign y_sh = ys >>> IDX;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r <= '0;
      y_r <= '0;
      z_r <= '0;
    end else if (zs >= 0) begin
      x_r <= xs - y_sh;
      y_r <= ys + x_sh;
      z_r <= zs - ATAN;
    end else begin
      x_r <= xs + y_sh;
      y_r <= ys - x_sh;
      z_r <= zs + ATAN;
    end
  end

`ifdef CORDIC_QUAD_EXT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) neg_r <= 1'b0;
    else     neg_r <= neg;
  end
`endif
endmodule

// File: rtl/cordic.sv
// Fully pipelined sin/cos of a Q2.5 angle, Q1.6 outputs, 10-cycle latency, one sample per cycle.
// Define CORDIC_QUAD_EXT_EN to fold angles beyond +/-pi/2 instead of clamping them.
module cordic #(
  parameter int ITER = cordic_pkg::ITER,
  parameter int IW   = cordic_pkg::IW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  output logic [7:0] sine,
  output logic [7:0] cosine
);
  import cordic_pkg::*;

  logic [IW-1:0] xs [0:ITER];
  logic [IW-1:0] ys [0:ITER];
  logic [IW-1:0] zs [0:ITER];

  logic signed [IW-1:0] z_raw, z_pre;
  assign z_raw = signed'({{(IW-8){in[7]}}, in}) <<< 4;

`ifdef CORDIC_QUAD_EXT_EN
  logic       neg_pre;
  logic [0:0] negs [0:ITER];

  // Fold by pi and remember to flip both results: sin/cos(a) = -sin/cos(a - pi).
  always_comb begin
    z_pre   = z_raw;
    neg_pre = 1'b0;
    if (z_raw > PI_HALF) begin
      z_pre   = z_raw - IW'(PI);
      neg_pre = 1'b1;
    end else if (z_raw < -PI_HALF) begin
      z_pre   = z_raw + IW'(PI);
      neg_pre = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) negs[0] <= 1'b0;
    else     negs[0] <= neg_pre;
  end
`else
  always_comb begin
    z_pre = z_raw;
    if (z_raw > PI_HALF)       z_pre = IW'(PI_HALF);
    else if (z_raw < -PI_HALF) z_pre = IW'(-PI_HALF);
  end
`endif

  // x starts at 1/K so the accumulated CORDIC gain lands on unit magnitude.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs[0] <= '0;
      ys[0] <= '0;
      zs[0] <= '0;
    end else begin
      xs[0] <= IW'(INV_K);
      ys[0] <= '0;
      zs[0] <= z_pre;
    end
  end

  for (genvar i = 0; i < ITER; i++) begin : g_stage
    cordic_stage #(.IDX(i), .IW(IW)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .x     (xs[i]),
      .y     (ys[i]),
      .z     (zs[i]),
`ifdef CORDIC_QUAD_EXT_EN
      .neg   (negs[i][0]),
      .neg_r (negs[i+1][0]),
`endif
      .x_r   (xs[i+1]),
      .y_r   (ys[i+1]),
      .z_r   (zs[i+1])
    );
  end

  logic signed [IW:0] cos_ext, sin_ext, cos_rnd, sin_rnd, cos_fin, sin_fin;

  assign cos_ext = signed'({xs[ITER][IW-1], xs[ITER]});
  assign sin_ext = signed'({ys[ITER][IW-1], ys[ITER]});
  assign cos_rnd = (cos_ext + (IW+1)'(8)) >>> 4;
  assign sin_rnd = (sin_ext + (IW+1)'(8)) >>> 4;

`ifdef CORDIC_QUAD_EXT_EN
  assign cos_fin = negs[ITER][0] ? -cos_rnd : cos_rnd;
  assign sin_fin = negs[ITER][0] ? -sin_rnd : sin_rnd;
`else
  assign cos_fin = cos_rnd;
  assign sin_fin = sin_rnd;
`endif

  function automatic logic [7:0] sat8(input logic signed [IW:0] v);
    if (v > 127)       return 8'h7f;
    else if (v < -128) return 8'h80;
    else               return v[7:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sine   <= '0;
      cosine <= '0;
    end else begin
      sine   <= sat8(sin_fin);
      cosine <= sat8(cos_fin);
    end
  end
endmodule

// File: tb/tb_cordic.sv
// Self-checking bench for cordic: directed angles, back-to-back stream, mid-stream reset, random stream.
// Expected values come from real-valued sin/cos of the (clamped or folded) input angle.
module tb_cordic;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in  = 8'd0;
  logic [7:0] sine, cosine;

  int checks = 0;
  int errors = 0;

  logic [7:0] hist [$];
  int         since_rst = 0;

  cordic dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .sine   (sine),
    .cosine (cosine)
  );

  always #5 clk = ~clk;

  function automatic int round_int(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  // Ideal Q1.6 result for an 8-bit Q2.5 angle.
  function automatic int ref_trig(input logic [7:0] a, input bit want_sin);
    int  z;
    real ang;
    z = int'($signed(a)) * 16;
`ifndef CORDIC_QUAD_EXT_EN
    if (z > 804)  z = 804;
    if (z < -804) z = -804;
`endif
    ang = real'(z) / 512.0;
    if (want_sin) return round_int(64.0 * $sin(ang));
    else          return round_int(64.0 * $cos(ang));
  endfunction

  task automatic check_tol(input string tag, input logic [7:0] got, input int exp);
    int g;
    g = int'($signed(got));
    checks++;
    assert (((g - exp <= 2) && (exp - g <= 2)) === 1'b1)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d (+/-2)", tag, g, exp);
    end
  endtask

  task automatic check_exact(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Drive one sample, clock it in, then compare the output against the sample taken 9 edges earlier.
  task automatic tick(input logic [7:0] v);
    logic [7:0] a;
    in = v;
    @(posedge clk);
    hist.push_back(v);
    since_rst++;
    #1;
    if (since_rst >= 10) begin
      a = hist[hist.size() - 10];
      check_tol("stream_sine", sine, ref_trig(a, 1'b1));
      check_tol("stream_cosine", cosine, ref_trig(a, 1'b0));
    end
  endtask

  task automatic hold(input logic [7:0] v, input int exp_s, input int exp_c, input string tag);
    for (int k = 0; k < 10; k++) tick(v);
    check_tol({tag, "_sine"}, sine, exp_s);
    check_tol({tag, "_cosine"}, cosine, exp_c);
  endtask

  initial begin
    #1;
    check_exact("reset_sine", sine, 8'd0);
    check_exact("reset_cosine", cosine, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    hold(8'd0, 0, 64, "zero");
    hold(8'd47, 64, 7, "in47");
    hold(8'(-25), -45, 45, "in_m25");
`ifdef CORDIC_QUAD_EXT_EN
    hold(8'd100, 1, -64, "in100");
`else
    hold(8'd100, 64, 0, "in100");
`endif

    tick(8'd0);
    tick(8'd47);
    tick(8'(-25));
    for (int k = 0; k < 7; k++) tick(8'd0);
    check_tol("b2b0_sine", sine, 0);
    check_tol("b2b0_cosine", cosine, 64);
    tick(8'd0);
    check_tol("b2b1_sine", sine, 64);
    check_tol("b2b1_cosine", cosine, 7);
    tick(8'd0);
    check_tol("b2b2_sine", sine, -45);
    check_tol("b2b2_cosine", cosine, 45);

    for (int k = 0; k < 20; k++) tick(8'($urandom_range(0, 255)));

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst = 1'b1;
    #1;
    check_exact("async_rst_sine", sine, 8'd0);
    check_exact("async_rst_cosine", cosine, 8'd0);
    @(posedge clk);
    #1;
    check_exact("held_rst_sine", sine, 8'd0);
    check_exact("held_rst_cosine", cosine, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    since_rst = 0;
    hold(8'd47, 64, 7, "post_rst");

    for (int k = 0; k < 300; k++) tick(8'($urandom_range(0, 255)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
